// File: rtl/matmul_seq_ctrl_if.sv
// ============================================================================
// Module : matmul_seq_ctrl_if
// Brief  : Control bus between the matmul sequencer and its host/datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface matmul_seq_ctrl_if #(
    parameter int AW = 6,
    parameter int LW = 1
);
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          mac_en;
    logic          mac_first;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [LW-1:0] c_lane;
    logic [15:0]   cycle_count;

    // Sequencer side
    modport master (
        input  start,
        output busy, done, a_addr, b_addr, mac_en, mac_first,
               c_we, c_addr, c_lane, cycle_count
    );

    // Host / datapath side
    modport slave (
        output start,
        input  busy, done, a_addr, b_addr, mac_en, mac_first,
               c_we, c_addr, c_lane, cycle_count
    );
endinterface

`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
// ============================================================================
// Module : matmul_seq_ctrl
// Brief  : Address/control sequencer for an NxN signed matrix multiply.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module matmul_seq_ctrl #(
    parameter int N     = 8,
    parameter int LANES = 2,
    parameter int AW    = 6,
    parameter int LW    = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    matmul_seq_ctrl_if.master   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            flush_q, flush_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [AW-1:0]   a_addr_q, a_addr_d;
    logic [AW-1:0]   b_addr_q, b_addr_d;
    logic            mac_en_q, mac_en_d;
    logic            mac_first_q, mac_first_d;
    logic            c_we_q, c_we_d;
    logic [AW-1:0]   c_addr_q, c_addr_d;
    logic [LW-1:0]   c_lane_q, c_lane_d;
    logic [15:0]     cycle_count_q, cycle_count_d;

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        lane_d        = lane_q;
        flush_d       = flush_q;
        cycle_count_d = cycle_count_q;

        if ((state_q == S_RUN || state_q == S_FLUSH || state_q == S_WRITE) &&
            (cycle_count_q != 16'hFFFF))
            cycle_count_d = cycle_count_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d       = S_RUN;
                    i_d           = '0;
                    j_d           = '0;
                    k_d           = '0;
                    lane_d        = '0;
                    cycle_count_d = '0;
                end
            end
            S_RUN: begin
                if (k_q == IW'(N - 1)) begin
                    state_d = S_FLUSH;
                    k_d     = '0;
                    flush_d = 1'b0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_q) begin
                    state_d = S_WRITE;
                    lane_d  = '0;
                end else begin
                    flush_d = 1'b1;
                end
            end
            S_WRITE: begin
                if (lane_q == LW'(LANES - 1)) begin
                    lane_d = '0;
                    if (int'(i_q) + LANES >= N) begin
                        i_d = '0;
                        if (j_q == IW'(N - 1)) begin
                            j_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            j_d     = j_q + 1'b1;
                            state_d = S_RUN;
                        end
                    end else begin
                        i_d     = i_q + IW'(LANES);
                        state_d = S_RUN;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it
        busy_d      = (state_d == S_RUN) || (state_d == S_FLUSH) || (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
        a_addr_d    = (state_d == S_RUN) ? AW'(k_d) * AW'(N) + AW'(i_d) : '0;
        b_addr_d    = (state_d == S_RUN) ? AW'(j_d) * AW'(N) + AW'(k_d) : '0;
        mac_en_d    = (state_q == S_RUN);
        mac_first_d = (state_q == S_RUN) && (k_q == '0);
        c_we_d      = (state_d == S_WRITE);
        c_lane_d    = (state_d == S_WRITE) ? lane_d : '0;
        c_addr_d    = (state_d == S_WRITE) ?
                      (AW'(i_d) + AW'(lane_d)) * AW'(N) + AW'(j_d) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            lane_q        <= '0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            a_addr_q      <= '0;
            b_addr_q      <= '0;
            mac_en_q      <= 1'b0;
            mac_first_q   <= 1'b0;
            c_we_q        <= 1'b0;
            c_addr_q      <= '0;
            c_lane_q      <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            lane_q        <= lane_d;
            flush_q       <= flush_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            a_addr_q      <= a_addr_d;
            b_addr_q      <= b_addr_d;
            mac_en_q      <= mac_en_d;
            mac_first_q   <= mac_first_d;
            c_we_q        <= c_we_d;
            c_addr_q      <= c_addr_d;
            c_lane_q      <= c_lane_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.a_addr      = a_addr_q;
    assign bus.b_addr      = b_addr_q;
    assign bus.mac_en      = mac_en_q;
    assign bus.mac_first   = mac_first_q;
    assign bus.c_we        = c_we_q;
    assign bus.c_addr      = c_addr_q;
    assign bus.c_lane      = c_lane_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
// ============================================================================
// Module : tb_matmul_seq_ctrl
// Brief  : Self-checking bench: cycle trace model plus a behavioural RAM/MAC datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_matmul_seq_ctrl;
    localparam int N     = 8;
    localparam int L     = 2;
    localparam int AW    = 6;
    localparam int LW    = 1;
    localparam int TOTAL = (N * N / L) * (N + 2 + L);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if #(.AW(AW), .LW(LW)) bus ();

    matmul_seq_ctrl #(.N(N), .LANES(L), .AW(AW), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic          men;
        logic          mf;
        logic          cwe;
        logic [AW-1:0] ca;
        logic [LW-1:0] cl;
        logic [15:0]   cnt;
    } rec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    rec_t exp_q[$];

    // Behavioural datapath: 1-cycle RAM reads, registered MACs, RAM C
    logic signed [7:0]  ram_a [N*N];
    logic signed [7:0]  ram_b [N*N];
    logic signed [31:0] ram_c [N*N];
    logic signed [7:0]  a_rd  [L];
    logic signed [7:0]  b_rd;
    logic signed [31:0] acc   [L];
    logic               clr_c = 1'b0;

    function automatic int mul(input logic signed [7:0] x, input logic signed [7:0] y);
        return int'(x) * int'(y);
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < L; l++) begin
            a_rd[l] <= ram_a[(int'(bus.a_addr) + l) % (N * N)];
            if (bus.mac_en)
                acc[l] <= (bus.mac_first ? 32'sd0 : acc[l]) + mul(a_rd[l], b_rd);
        end
        b_rd <= ram_b[bus.b_addr];
        if (clr_c) begin
            for (int x = 0; x < N * N; x++) ram_c[x] <= 32'h0BAD_0BAD;
        end else if (bus.c_we) begin
            ram_c[bus.c_addr] <= acc[bus.c_lane];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, req);
        end
    endtask

    function automatic rec_t dut_rec();
        rec_t r;
        r.busy = bus.busy;    r.done = bus.done;
        r.a    = bus.a_addr;  r.b    = bus.b_addr;
        r.men  = bus.mac_en;  r.mf   = bus.mac_first;
        r.cwe  = bus.c_we;    r.ca   = bus.c_addr;
        r.cl   = bus.c_lane;  r.cnt  = bus.cycle_count;
        return r;
    endfunction

    // Expected per-cycle outputs from the loop nest: j outer, i by L, k inner
    task automatic build_trace();
        rec_t r;
        int   n = 0;
        exp_q.delete();
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i += L) begin
                for (int k = 0; k < N; k++) begin
                    r = '0; r.busy = 1'b1; r.cnt = 16'(n++);
                    r.a = AW'(k * N + i); r.b = AW'(j * N + k);
                    r.men = (k > 0); r.mf = (k == 1);
                    exp_q.push_back(r);
                end
                r = '0; r.busy = 1'b1; r.men = 1'b1; r.cnt = 16'(n++);
                exp_q.push_back(r);
                r = '0; r.busy = 1'b1; r.cnt = 16'(n++);
                exp_q.push_back(r);
                for (int l = 0; l < L; l++) begin
                    r = '0; r.busy = 1'b1; r.cwe = 1'b1; r.cnt = 16'(n++);
                    r.ca = AW'((i + l) * N + j); r.cl = LW'(l);
                    exp_q.push_back(r);
                end
            end
        end
        r = '0; r.done = 1'b1; r.cnt = 16'(TOTAL);
        exp_q.push_back(r);
        r = '0; r.cnt = 16'(TOTAL);
        for (int x = 0; x < 3; x++) exp_q.push_back(r);
    endtask

    task automatic run(input string tag, input int mid_pulse, input int abort_at);
        int   done_cnt = 0, we_cnt = 0, busy_cnt = 0, cnt_at_done = -1;
        int   hit [N*N];
        int   cover_ok;
        for (int x = 0; x < N * N; x++) hit[x] = 0;
        @(negedge clk) clr_c = 1'b1; bus.start = 1'b1;
        @(negedge clk) clr_c = 1'b0;
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            bus.start = (idx == mid_pulse || idx == TOTAL);
            if (idx == abort_at) begin
                bus.start = 1'b0;
                #1 rst = 1'b1;
                #1 check({tag, "_abort_outputs_zero"}, 64'(dut_rec()), 64'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                return;
            end
            check($sformatf("%s_trace[%0d]", tag, idx), 64'(dut_rec()), 64'(exp_q[idx]));
            if (bus.done) begin done_cnt++; cnt_at_done = int'(bus.cycle_count); end
            if (bus.busy) busy_cnt++;
            if (bus.c_we) begin we_cnt++; hit[bus.c_addr]++; end
            @(negedge clk);
        end
        bus.start = 1'b0;
        cover_ok = 1;
        for (int x = 0; x < N * N; x++) if (hit[x] != 1) cover_ok = 0;
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_c_we_strobes"}, 64'(we_cnt), 64'd64);
        check({tag, "_c_addr_each_once"}, 64'(cover_ok), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd384);
        check({tag, "_cycle_count"}, 64'(cnt_at_done), 64'd384);
    endtask

    task automatic check_c(input string tag);
        int s;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += mul(ram_a[k * N + i], ram_b[j * N + k]);
                check($sformatf("%s_C[%0d][%0d]", tag, i, j), 64'(ram_c[i * N + j]), 64'(s));
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle_after_reset", 64'(dut_rec()), 64'd0);
        end

        // Pin the trace model to hand-derived values for tile (i=0,j=0)
        build_trace();
        check("model_len",       64'(exp_q.size()), 64'd388);
        check("model_a_k0",      64'(exp_q[0].a),   64'd0);
        check("model_a_k7",      64'(exp_q[7].a),   64'd56);
        check("model_b_k7",      64'(exp_q[7].b),   64'd7);
        check("model_mf_first",  64'(exp_q[1].mf),  64'd1);
        check("model_flush_men", 64'(exp_q[8].men), 64'd1);
        check("model_lane0_ca",  64'(exp_q[10].ca), 64'd0);
        check("model_lane1_ca",  64'(exp_q[11].ca), 64'd8);

        for (int x = 0; x < N * N; x++) begin
            ram_a[x] = 8'(x * 37 + 5);
            ram_b[x] = 8'(x * 53 + 200);
        end
        run("pattern", -1, -1);
        check_c("pattern");

        for (int x = 0; x < N * N; x++) ram_a[x] = ((x / N) == (x % N)) ? 8'sd1 : 8'sd0;
        run("identity_midstart", 150, -1);
        check_c("identity");
        check("identity_C12_is_B_transposed", 64'(ram_c[1 * N + 2]), 64'(ram_b[2 * N + 1]));

        for (int x = 0; x < N * N; x++) begin
            ram_a[x] = -8'sd128;
            ram_b[x] = -8'sd128;
        end
        run("neg128", -1, -1);
        check("neg128_C00", 64'(ram_c[0]),  64'd131072);
        check("neg128_C77", 64'(ram_c[63]), 64'd131072);

        run("abort", -1, 100);
        check("after_abort_idle", 64'(dut_rec()), 64'd0);
        for (int x = 0; x < N * N; x++) begin
            ram_a[x] = 8'(x * 11 + 3);
            ram_b[x] = 8'(200 - x * 7);
        end
        run("post_abort", -1, -1);
        check_c("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
